// File: rtl/multiword_adder_seq_if.sv
// Bundles the request/result handshake of multiword_adder_seq together with the
// word-wide link to the external fulladder32 stage.
interface multiword_adder_seq_if #(
    parameter int WORDS = 4
) ();
    localparam int N = WORDS * 32;

    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Pin;
    logic         busy;
    logic         done;
    logic [N-1:0] S;
    logic         Pout;
    logic         OVF;
    logic [31:0]  add_A;
    logic [31:0]  add_B;
    logic         add_Pin;
    logic [31:0]  add_S;
    logic         add_Pout;

    modport slave (
        input  start, A, B, Pin, add_S, add_Pout,
        output busy, done, S, Pout, OVF, add_A, add_B, add_Pin
    );

    modport master (
        output start, A, B, Pin, add_S, add_Pout,
        input  busy, done, S, Pout, OVF, add_A, add_B, add_Pin
    );
endinterface

// File: rtl/multiword_adder_seq.sv
// Wide adder sequencer: streams one 32-bit word pair per cycle through an
// external fulladder32, chaining the carry LSW-first.
//   state | meaning
//   IDLE  | waiting for start, adder inputs parked at zero
//   RUN   | one word per cycle, idx selects the word
//   DONE  | latch final carry and signed overflow
module multiword_adder_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    multiword_adder_seq_if.slave bus
);
    localparam int N  = WORDS * 32;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [N-1:0]  opa_q, opa_d;
    logic [N-1:0]  opb_q, opb_d;
    logic [N-1:0]  s_q, s_d;
    logic          pout_q, pout_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            s_q     <= '0;
            pout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            s_q     <= s_d;
            pout_q  <= pout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (idx_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        s_d     = s_q;
        pout_d  = pout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opa_d   = bus.A;
                    opb_d   = bus.B;
                    carry_d = bus.Pin;
                    idx_d   = '0;
                    s_d     = '0;
                    pout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                s_d[idx_q*32 +: 32] = bus.add_S;
                carry_d             = bus.add_Pout;
                if (idx_q != LAST) idx_d = idx_q + 1'b1;
            end
            DONE: begin
                // done is registered so it lines up with Pout/OVF becoming valid
                done_d = 1'b1;
                pout_d = carry_q;
                ovf_d  = (opa_q[N-1] == opb_q[N-1]) && (s_q[N-1] != opa_q[N-1]);
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.busy    = (state_q != IDLE);
        bus.done    = done_q;
        bus.S       = s_q;
        bus.Pout    = pout_q;
        bus.OVF     = ovf_q;
        bus.add_A   = '0;
        bus.add_B   = '0;
        bus.add_Pin = 1'b0;
        if (state_q == RUN) begin
            bus.add_A   = opa_q[idx_q*32 +: 32];
            bus.add_B   = opb_q[idx_q*32 +: 32];
            bus.add_Pin = carry_q;
        end
    end
endmodule

// File: tb/tb_multiword_adder_seq.sv
// Randomized bench for multiword_adder_seq with a behavioural fulladder32 and a
// wide-arithmetic reference model.
module tb_multiword_adder_seq;
    localparam int WORDS = 4;
    localparam int N     = WORDS * 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    multiword_adder_seq_if #(.WORDS(WORDS)) bus ();

    multiword_adder_seq #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // external fulladder32 stage
    assign {bus.add_Pout, bus.add_S} = 33'(bus.add_A) + 33'(bus.add_B) + 33'(bus.add_Pin);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [N:0] obs, input logic [N:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] rand_wide(input int mode);
        logic [N-1:0] r;
        for (int k = 0; k < WORDS; k++) begin
            case (mode)
                0:       r[k*32 +: 32] = $urandom;
                1:       r[k*32 +: 32] = ($urandom_range(1) == 1) ? 32'hFFFF_FFFF : $urandom;
                default: r[k*32 +: 32] = ($urandom_range(1) == 1) ? 32'h0 : 32'hFFFF_FFFF;
            endcase
        end
        return r;
    endfunction

    // carry entering word k = carry out of the low 32*k bits of a+b+pin
    function automatic logic carry_into(input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic pin, input int k);
        logic [N:0] m, t;
        if (k == 0) return pin;
        m = ({{N{1'b0}}, 1'b1} << (32 * k)) - 1'b1;
        t = ({1'b0, a} & m) + ({1'b0, b} & m) + (N+1)'(pin);
        return t[32*k];
    endfunction

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic pin, input bit noisy);
        logic [N:0] full;
        logic       ovf;
        int         lat;
        bit         seen;
        full = {1'b0, a} + {1'b0, b} + (N+1)'(pin);
        ovf  = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);

        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Pin   = pin;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = rand_wide(0);
        bus.B     = rand_wide(0);
        bus.Pin   = 1'($urandom_range(1));
        chk("busy_run", (N+1)'(bus.busy), (N+1)'(1));

        lat  = 0;
        seen = 0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            if (c <= WORDS) begin
                chk($sformatf("add_A_w%0d", c-1), (N+1)'(bus.add_A), (N+1)'(a[(c-1)*32 +: 32]));
                chk($sformatf("add_Pin_w%0d", c-1), (N+1)'(bus.add_Pin),
                    (N+1)'(carry_into(a, b, pin, c-1)));
            end
            bus.start = (noisy && (c == 2 || c == WORDS + 1)) ? 1'b1 : 1'b0;
            if (noisy) begin
                bus.A = rand_wide(0);
                bus.B = rand_wide(0);
            end
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                lat  = c;
            end
        end
        bus.start = 1'b0;
        chk("latency", (N+1)'(lat), (N+1)'(WORDS + 1));
        chk("S", (N+1)'(bus.S), (N+1)'(full[N-1:0]));
        chk("Pout", (N+1)'(bus.Pout), (N+1)'(full[N]));
        chk("OVF", (N+1)'(bus.OVF), (N+1)'(ovf));
        chk("busy_done", (N+1)'(bus.busy), '0);
        @(negedge clk);
        chk("done_pulse", (N+1)'(bus.done), '0);
        chk("S_hold", (N+1)'(bus.S), (N+1)'(full[N-1:0]));
    endtask

    task automatic reset_mid_run();
        int  dones;
        logic [N-1:0] a, b;
        a = rand_wide(0) | {{(N-1){1'b0}}, 1'b1};
        b = rand_wide(0);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Pin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_nonzero", (N+1)'(bus.S != '0), (N+1)'(1));
        rst = 1'b1;
        #1;
        chk("rst_busy", (N+1)'(bus.busy), '0);
        chk("rst_S", (N+1)'(bus.S), '0);
        chk("rst_done", (N+1)'(bus.done), '0);
        chk("rst_addPin", (N+1)'(bus.add_Pin), '0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("rst_no_done", (N+1)'(dones), '0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Pin   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_S", (N+1)'(bus.S), '0);
        chk("reset_busy", (N+1)'(bus.busy), '0);
        chk("reset_done", (N+1)'(bus.done), '0);
        chk("reset_addA", (N+1)'(bus.add_A), '0);
        rst = 1'b0;
        @(negedge clk);

        run_op(128'd1, 128'd0, 1'b0, 0);
        chk("t1_S_const", (N+1)'(bus.S), (N+1)'(1));
        run_op(128'hFFFF_FFFF, 128'd1, 1'b0, 0);
        chk("t2_S_const", (N+1)'(bus.S), (N+1)'(128'h1_0000_0000));
        run_op({N{1'b1}}, 128'd0, 1'b1, 0);
        chk("t3_Pout_const", (N+1)'(bus.Pout), (N+1)'(1));
        run_op({1'b0, {(N-1){1'b1}}}, 128'd1, 1'b0, 0);
        chk("t4_OVF_const", (N+1)'(bus.OVF), (N+1)'(1));
        run_op({1'b1, {(N-1){1'b0}}}, {1'b1, {(N-1){1'b0}}}, 1'b0, 0);
        chk("t4b_S_const", (N+1)'(bus.S), '0);

        run_op(rand_wide(0), rand_wide(0), 1'b1, 1);

        reset_mid_run();
        run_op(128'd100, 128'd300, 1'b0, 0);
        chk("t6_S_const", (N+1)'(bus.S), (N+1)'(400));

        for (int i = 0; i < 30; i++) begin
            run_op(rand_wide(i % 3), rand_wide((i + 1) % 3),
                   1'($urandom_range(1)), bit'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
